spi_lcd_rx: RTL and testbench



---
 rtl/spi_lcd_rx.sv | 206 ++++++++++++++++++++
 tb/tb_spi_lcd_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_lcd_rx.sv
// Receive-side decoder for a PCD8544-style serial display link: deserialises bytes,
// tracks the panel's X/Y RAM pointer and emits framebuffer writes. Define FRAME_CHECKSUM_EN for frame_sum.
module spi_lcd_rx #(
  parameter int COLS        = 84,
  parameter int ROWS        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        sce,
  input  logic        dc,
  input  logic        lcd_rst_n,
  output logic        fb_we,
  output logic [8:0]  fb_addr,
  output logic [7:0]  fb_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        frame_done,
  output logic        abort,
  output logic [15:0] frame_sum
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, sce_sr, dc_sr, lrst_sr;
  logic sclk_s, mosi_s, sce_s, dc_s, lrst_s, sclk_d;
  logic sclk_rise, byte_done, clr;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          dc_lat;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          h, v, pd;
  logic          pd_unused;
  logic [8:0]    cur_addr;
  logic          at_last;

  // Input synchronisers; sce and lcd_rst_n idle high so reset holds them inactive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      sce_sr  <= '1;
      dc_sr   <= '0;
      lrst_sr <= '1;
      sclk_d  <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sce_sr  <= {sce_sr[SYNC_STAGES-2:0], sce};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], dc};
      lrst_sr <= {lrst_sr[SYNC_STAGES-2:0], lcd_rst_n};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sce_s     = sce_sr[SYNC_STAGES-1];
  assign dc_s      = dc_sr[SYNC_STAGES-1];
  assign lrst_s    = lrst_sr[SYNC_STAGES-1];
  assign clr       = ~lrst_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign byte_done = (state == SHIFT) && sclk_rise && (bit_cnt == 3'd7);
  assign pd_unused = pd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A completing 8th edge wins over a simultaneous sce rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sce_s) state_nxt = SHIFT;
      SHIFT:   if (byte_done) state_nxt = DECODE;
               else if (sce_s) state_nxt = IDLE;
      DECODE:  state_nxt = sce_s ? IDLE : SHIFT;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  assign cur_addr = 9'(int'(y) * COLS + int'(x));
  assign at_last  = (x == X_LAST) && (y == Y_LAST);

  always_comb begin
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    frame_done = 1'b0;
    cmd_valid  = 1'b0;
    cmd_byte   = '0;
    abort      = 1'b0;
    if (!clr) begin
      if (state == DECODE) begin
        if (dc_lat) begin
          fb_we      = 1'b1;
          fb_addr    = cur_addr;
          fb_data    = shreg;
          frame_done = at_last;
        end else begin
          cmd_valid = 1'b1;
          cmd_byte  = shreg;
        end
      end
      if ((state == SHIFT) && sce_s && (bit_cnt != 3'd0) && !byte_done) abort = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      dc_lat  <= 1'b0;
    end else if (clr || state != SHIFT) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_done) dc_lat <= dc_s;
    end
  end

  always_ff @(posedge clk) begin
    if (state == SHIFT && sclk_rise) shreg <= {shreg[6:0], mosi_s};
  end

  // Pointer and function-set state follow the panel's own addressing rules
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x  <= '0;
      y  <= '0;
      h  <= 1'b0;
      v  <= 1'b0;
      pd <= 1'b0;
    end else if (clr) begin
      x  <= '0;
      y  <= '0;
      h  <= 1'b0;
      v  <= 1'b0;
      pd <= 1'b0;
    end else if (state == DECODE) begin
      if (dc_lat) begin
        if (!v) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end else begin
          if (y == Y_LAST) begin
            y <= '0;
            x <= (x == X_LAST) ? '0 : x + XW'(1);
          end else begin
            y <= y + YW'(1);
          end
        end
      end else if (shreg[7:3] == 5'b00100) begin
        pd <= shreg[2];
        v  <= shreg[1];
        h  <= shreg[0];
      end else if (!h && shreg[7]) begin
        if (32'(shreg[6:0]) < COLS) x <= XW'(shreg[6:0]);
      end else if (!h && shreg[7:3] == 5'b01000) begin
        if (32'(shreg[2:0]) < ROWS) y <= YW'(shreg[2:0]);
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] acc, sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      sum_q <= '0;
    end else if (clr) begin
      acc   <= '0;
      sum_q <= '0;
    end else if (fb_we) begin
      if (frame_done) begin
        sum_q <= acc + {8'h00, shreg};
        acc   <= '0;
      end else begin
        acc <= acc + {8'h00, shreg};
      end
    end
  end

  assign frame_sum = clr ? '0 : sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Randomised bench for spi_lcd_rx: drives the serial link and compares every write,
// command and abort against an address-arithmetic model of the panel pointer.
module tb_spi_lcd_rx;
  localparam int COLS  = 84;
  localparam int ROWS  = 6;
  localparam int NADDR = COLS * ROWS;
  localparam int SYNC  = 2;

  logic clk = 0, rst = 1, sclk = 0, mosi = 0, sce = 1, dc = 0, lcd_rst_n = 1;
  logic        fb_we, cmd_valid, frame_done, abort;
  logic [8:0]  fb_addr;
  logic [7:0]  fb_data, cmd_byte;
  logic [15:0] frame_sum;

  spi_lcd_rx #(.COLS(COLS), .ROWS(ROWS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc),
    .lcd_rst_n(lcd_rst_n), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_done(frame_done),
    .abort(abort), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rise_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] qa[$];
  logic [7:0] qd[$];
  logic       qf[$];
  int         ql[$];
  logic [7:0] qc[$];
  int         qcl[$];
  int abort_cnt = 0, stray_fd = 0;

  always @(negedge clk) begin
    if (fb_we) begin
      qa.push_back(fb_addr); qd.push_back(fb_data); qf.push_back(frame_done);
      ql.push_back(cyc - rise_cyc);
    end else if (frame_done) stray_fd++;
    if (cmd_valid) begin
      qc.push_back(cmd_byte); qcl.push_back(cyc - rise_cyc);
    end
    if (abort) abort_cnt++;
  end

  int n_chk = 0, n_fail = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Panel model: pointer as a linear index in write order
  int mx, my, mh, mv, mpd, macc, mfsum;
  task automatic model_reset();
    mx = 0; my = 0; mh = 0; mv = 0; mpd = 0; macc = 0; mfsum = 0;
  endtask

  task automatic model_byte(input bit d, input logic [7:0] b, output int addr, output bit fd);
    int idx, n;
    addr = my * COLS + mx;
    fd = 0;
    if (d) begin
      if (mv == 0) begin
        idx = addr;
        n = (idx + 1) % NADDR;
        mx = n % COLS; my = n / COLS;
      end else begin
        idx = mx * ROWS + my;
        n = (idx + 1) % NADDR;
        mx = n / ROWS; my = n % ROWS;
      end
      fd = (idx == NADDR - 1);
      macc = (macc + int'(b)) % 65536;
      if (fd) begin mfsum = macc; macc = 0; end
    end else if (b[7:3] == 5'b00100) begin
      mpd = int'(b[2]); mv = int'(b[1]); mh = int'(b[0]);
    end else if (mh == 0 && b[7]) begin
      if (int'(b[6:0]) < COLS) mx = int'(b[6:0]);
    end else if (mh == 0 && b[7:3] == 5'b01000) begin
      if (int'(b[2:0]) < ROWS) my = int'(b[2:0]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit sce_last);
    int w;
    for (int i = 0; i < n; i++) begin
      w = $urandom_range(2, 3);
      sclk = 0; mosi = b[7-i];
      tick(w);
      sclk = 1;
      if (sce_last && i == n - 1) sce = 1;
      rise_cyc = cyc;
      tick(w);
    end
  endtask

  function automatic logic [15:0] exp_sum();
`ifdef FRAME_CHECKSUM_EN
    return 16'(mfsum);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic clear_q();
    qa.delete(); qd.delete(); qf.delete(); ql.delete(); qc.delete(); qcl.delete();
  endtask

  task automatic xfer(input bit d, input logic [7:0] b, input bit sce_last);
    int ea;
    bit efd;
    dc = d;
    send_bits(b, 8, sce_last);
    sclk = 0;
    tick(4);
    model_byte(d, b, ea, efd);
    if (d) begin
      check_eq("fb_we_count", qa.size(), 1);
      check_eq("cmd_count_on_data", qc.size(), 0);
      if (qa.size() > 0) begin
        check_eq("fb_addr", qa.pop_front(), ea);
        check_eq("fb_data", qd.pop_front(), b);
        check_eq("frame_done", qf.pop_front(), efd);
        check_eq("fb_latency", ql.pop_front(), SYNC + 1);
      end
    end else begin
      check_eq("cmd_count", qc.size(), 1);
      check_eq("fb_count_on_cmd", qa.size(), 0);
      if (qc.size() > 0) begin
        check_eq("cmd_byte", qc.pop_front(), b);
        check_eq("cmd_latency", qcl.pop_front(), SYNC + 1);
      end
    end
    check_eq("frame_sum", frame_sum, exp_sum());
    clear_q();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_fb_we"}, fb_we, 0);
    check_eq({tag, "_fb_addr"}, fb_addr, 0);
    check_eq({tag, "_fb_data"}, fb_data, 0);
    check_eq({tag, "_cmd_valid"}, cmd_valid, 0);
    check_eq({tag, "_cmd_byte"}, cmd_byte, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
    check_eq({tag, "_abort"}, abort, 0);
    check_eq({tag, "_frame_sum"}, frame_sum, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab0, r;
    bit seen;
    logic [7:0] b;
    model_reset();
    tick(3);
    check_outputs_zero("reset");
    rst = 0;
    tick(2);
    sce = 0;
    tick(3);

    // Basic command decode and first write
    xfer(0, 8'h21, 0);
    xfer(0, 8'h20, 0);
    xfer(0, 8'h8A, 0);
    xfer(0, 8'h42, 0);
    xfer(1, 8'hA5, 0);

    // Wrap from last address
    xfer(0, 8'hD3, 0);
    xfer(0, 8'h45, 0);
    xfer(1, 8'h3C, 0);
    xfer(1, 8'h11, 0);

    // Vertical addressing
    xfer(0, 8'h22, 0);
    xfer(0, 8'h80, 0);
    xfer(0, 8'h40, 0);
    for (int i = 0; i < 7; i++) xfer(1, 8'($urandom_range(0, 255)), 0);
    xfer(0, 8'h20, 0);

    // Partial byte then sce rise
    ab0 = abort_cnt;
    dc = 1;
    send_bits(8'hE0, 5, 0);
    sce = 1; sclk = 0;
    tick(5);
    check_eq("abort_count", abort_cnt - ab0, 1);
    check_eq("abort_no_write", qa.size(), 0);
    clear_q();
    sce = 0;
    tick(3);
    xfer(1, 8'hFF, 0);

    // 8th edge coincident with sce rise completes the byte
    ab0 = abort_cnt;
    xfer(1, 8'hC6, 1);
    check_eq("simul_no_abort", abort_cnt - ab0, 0);
    sce = 0;
    tick(3);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 9) begin
        sce = 1; tick($urandom_range(2, 4));
        sce = 0; tick(3);
      end
      case (r)
        0: xfer(0, 8'h20 | 8'($urandom_range(0, 7)), 0);
        1: xfer(0, 8'h80 | 8'($urandom_range(0, 127)), 0);
        2: xfer(0, 8'h40 | 8'($urandom_range(0, 7)), 0);
        3: xfer(0, 8'($urandom_range(0, 255)), 0);
        default: xfer(1, 8'($urandom_range(0, 255)), 0);
      endcase
    end

    // Display reset mid-byte with pointer at 37,3
    xfer(0, 8'h20, 0);
    xfer(0, 8'hA5, 0);
    xfer(0, 8'h43, 0);
    ab0 = abort_cnt;
    dc = 1;
    send_bits(8'hC3, 3, 0);
    sclk = 0;
    tick(1);
    lcd_rst_n = 0;
    tick(4);
    check_outputs_zero("lcdrst");
    lcd_rst_n = 1;
    tick(4);
    model_reset();
    check_eq("lcdrst_no_abort", abort_cnt - ab0, 0);
    check_eq("lcdrst_no_write", qa.size(), 0);
    clear_q();
    xfer(1, 8'h77, 0);

    // Asynchronous reset while a write strobe is active
    dc = 1;
    send_bits(8'h5A, 8, 0);
    sclk = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (fb_we) begin seen = 1; break; end
    end
    check_eq("rst_fb_we_seen", seen, 1);
    rst = 1;
    #1;
    check_outputs_zero("async_rst");
    tick(3);
    rst = 0;
    sce = 1;
    tick(3);
    model_reset();
    clear_q();
    sce = 0;
    tick(3);

    // Full frame of 0x01 bytes
    for (int i = 0; i < NADDR; i++) xfer(1, 8'h01, 0);
`ifdef FRAME_CHECKSUM_EN
    check_eq("frame_sum_full", frame_sum, 16'h01F8);
`else
    check_eq("frame_sum_full", frame_sum, 16'h0000);
`endif
    check_eq("stray_frame_done", stray_fd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
